// File: rtl/hpi_xfer_ctrl_if.sv
// ----------------------------------------------------------------------------
// hpi_xfer_ctrl_if
// Bundles the request/response handshake and the HPI I/O-side bus of
// hpi_xfer_ctrl into a single interface.
//
// Modports
//   slave  : the transfer controller itself (accepts requests and drives
//            the HPI strobes, port select and write data).
//   master : the environment around it, meaning the requesting client plus
//            the HPI I/O block that returns registered read data.
//
// Signals
//   req_valid/req_ready        request handshake
//   req_write/req_addr/req_wdata   request payload
//   rsp_valid/rsp_rdata        one-cycle completion pulse and read result
//   hpi_address                HPI port select (00 DATA, 10 ADDRESS)
//   hpi_data_out/hpi_data_in   HPI write data out, registered read data in
//   hpi_r_n/hpi_w_n/hpi_cs_n   active-low read, write and chip-select
// ----------------------------------------------------------------------------
interface hpi_xfer_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [1:0]  hpi_address;
    logic [15:0] hpi_data_out;
    logic [15:0] hpi_data_in;
    logic        hpi_r_n;
    logic        hpi_w_n;
    logic        hpi_cs_n;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, hpi_data_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  hpi_address, hpi_data_out, hpi_r_n, hpi_w_n, hpi_cs_n
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, hpi_data_in,
        output req_ready, rsp_valid, rsp_rdata,
        output hpi_address, hpi_data_out, hpi_r_n, hpi_w_n, hpi_cs_n
    );
endinterface

// File: rtl/hpi_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// hpi_xfer_ctrl
// Sequences one CY7C67200 memory access over the HPI I/O interface per
// accepted request: first the target address is written to the HPI ADDRESS
// port, then the data word is written to or read from the HPI DATA port,
// followed by a chip-select-high recovery gap.
//
// Parameters
//   STROBE_CYC : RD/WR strobe low width in clocks (3..15)
//   RECOV_CYC  : CS-high recovery clocks between transactions (1..15)
//
// Ports
//   Clk   : clock, all state changes on the rising edge
//   Reset : asynchronous, active-high reset
//   bus   : hpi_xfer_ctrl_if.slave (request/response handshake + HPI bus)
//
// Every hpi_* output is a flop loaded with the value belonging to the state
// being entered, so the strobes are glitch-free and line up exactly with the
// FSM state.
// ----------------------------------------------------------------------------
module hpi_xfer_ctrl #(
    parameter int STROBE_CYC = 4,
    parameter int RECOV_CYC  = 2
) (
    input logic             Clk,
    input logic             Reset,
    hpi_xfer_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        RECOV
    } state_t;

    localparam logic [1:0] PORT_DATA = 2'b00;
    localparam logic [1:0] PORT_ADDR = 2'b10;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [15:0] lat_wdata;

    // The address is loaded straight into hpi_data_out on the accepting
    // edge, so only the direction and the write data need holding.
    // cnt counts down the remaining cycles of the multi-cycle states.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state            <= IDLE;
            cnt              <= '0;
            lat_write        <= 1'b0;
            lat_wdata        <= '0;
            bus.req_ready    <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.hpi_address  <= PORT_DATA;
            bus.hpi_data_out <= '0;
            bus.hpi_r_n      <= 1'b1;
            bus.hpi_w_n      <= 1'b1;
            bus.hpi_cs_n     <= 1'b1;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // req_ready comes up one edge after entering IDLE from
                    // reset; a request is only taken once it is visibly high.
                    if (bus.req_valid && bus.req_ready) begin
                        lat_write        <= bus.req_write;
                        lat_wdata        <= bus.req_wdata;
                        bus.req_ready    <= 1'b0;
                        bus.hpi_cs_n     <= 1'b0;
                        bus.hpi_address  <= PORT_ADDR;
                        bus.hpi_data_out <= bus.req_addr;
                        state            <= A_SETUP;
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                A_SETUP: begin
                    bus.hpi_w_n <= 1'b0;
                    cnt         <= 4'(STROBE_CYC - 1);
                    state       <= A_STROBE;
                end
                A_STROBE: begin
                    if (cnt == 4'd0) begin
                        bus.hpi_w_n <= 1'b1;
                        state       <= A_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                A_HOLD: begin
                    bus.hpi_address  <= PORT_DATA;
                    bus.hpi_data_out <= lat_write ? lat_wdata : 16'h0000;
                    state            <= D_SETUP;
                end
                D_SETUP: begin
                    bus.hpi_w_n <= ~lat_write;
                    bus.hpi_r_n <= lat_write;
                    cnt         <= 4'(STROBE_CYC - 1);
                    state       <= D_STROBE;
                end
                D_STROBE: begin
                    // Read data is taken while the read strobe is still low,
                    // on the edge that ends the last strobe cycle.
                    if (cnt == 4'd0) begin
                        bus.hpi_w_n <= 1'b1;
                        bus.hpi_r_n <= 1'b1;
                        if (!lat_write) begin
                            bus.rsp_rdata <= bus.hpi_data_in;
                        end
                        state <= D_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                D_HOLD: begin
                    bus.hpi_cs_n     <= 1'b1;
                    bus.hpi_address  <= PORT_DATA;
                    bus.hpi_data_out <= 16'h0000;
                    bus.rsp_valid    <= 1'b1;
                    cnt              <= 4'(RECOV_CYC - 1);
                    state            <= RECOV;
                end
                RECOV: begin
                    if (cnt == 4'd0) begin
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hpi_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hpi_xfer_ctrl
// Self-checking bench for hpi_xfer_ctrl. Instance A uses the default timing
// (STROBE_CYC=4, RECOV_CYC=2) and instance B the shortest legal timing
// (STROBE_CYC=3, RECOV_CYC=1). Each transaction is checked cycle by cycle
// against an expected-timeline model built from the strobe and recovery
// lengths. Cycle k is the clock period that ends at the k-th rising edge
// after the accepting edge, which itself ends cycle 0.
// ----------------------------------------------------------------------------
module tb_hpi_xfer_ctrl;

    logic Clk;
    logic Reset;

    hpi_xfer_ctrl_if bus_a ();
    hpi_xfer_ctrl_if bus_b ();

    hpi_xfer_ctrl #(.STROBE_CYC(4), .RECOV_CYC(2)) dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_a.slave)
    );

    hpi_xfer_ctrl #(.STROBE_CYC(3), .RECOV_CYC(1)) dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_b.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] rd_value = 16'h0000;
    bit          mon_on   = 1'b0;

    localparam logic [22:0] RESET_VEC = {1'b1, 1'b1, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b0};
    localparam logic [22:0] READY_VEC = {1'b1, 1'b1, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // HPI I/O side model: read data comes back one clock after the read
    // strobe is seen low on the DATA port.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus_a.hpi_data_in <= 16'h0000;
            bus_b.hpi_data_in <= 16'h0000;
        end else begin
            bus_a.hpi_data_in <= (!bus_a.hpi_r_n && !bus_a.hpi_cs_n && bus_a.hpi_address == 2'b00) ? rd_value : 16'h0000;
            bus_b.hpi_data_in <= (!bus_b.hpi_r_n && !bus_b.hpi_cs_n && bus_b.hpi_address == 2'b00) ? rd_value : 16'h0000;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic logic [22:0] getVec(input int which);
        if (which == 0)
            return {bus_a.hpi_cs_n, bus_a.hpi_r_n, bus_a.hpi_w_n, bus_a.hpi_address,
                    bus_a.hpi_data_out, bus_a.rsp_valid, bus_a.req_ready};
        return {bus_b.hpi_cs_n, bus_b.hpi_r_n, bus_b.hpi_w_n, bus_b.hpi_address,
                bus_b.hpi_data_out, bus_b.rsp_valid, bus_b.req_ready};
    endfunction

    function automatic logic getReady(input int which);
        return (which == 0) ? bus_a.req_ready : bus_b.req_ready;
    endfunction

    function automatic logic [15:0] getRdata(input int which);
        return (which == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata;
    endfunction

    // 1 when either strobe rule is broken: both strobes low, or a strobe
    // low while chip select is high.
    function automatic logic strobeViolation(input logic cs_n, input logic r_n, input logic w_n);
        return (!r_n && !w_n) || ((!r_n || !w_n) && cs_n);
    endfunction

    task automatic driveReq(input int which, input logic v, input logic wr,
                            input logic [15:0] addr, input logic [15:0] wdata);
        if (which == 0) begin
            bus_a.req_valid = v;
            bus_a.req_write = wr;
            bus_a.req_addr  = addr;
            bus_a.req_wdata = wdata;
        end else begin
            bus_b.req_valid = v;
            bus_b.req_write = wr;
            bus_b.req_addr  = addr;
            bus_b.req_wdata = wdata;
        end
    endtask

    // Expected {cs_n, r_n, w_n, address, data_out, rsp_valid, req_ready}
    // in cycle k of a transaction with strobe length s and recovery length r.
    function automatic logic [22:0] expVec(input int k, input int s, input int r, input logic wr,
                                           input logic [15:0] addr, input logic [15:0] wdata);
        logic        cs, rn, wn, rv, rdy;
        logic [1:0]  ad;
        logic [15:0] d, dd;
        cs = 1'b1; rn = 1'b1; wn = 1'b1; rv = 1'b0; rdy = 1'b0;
        ad = 2'b00; d = 16'h0000;
        dd = wr ? wdata : 16'h0000;
        if (k == 1) begin
            cs = 1'b0; ad = 2'b10; d = addr;
        end else if (k <= 1 + s) begin
            cs = 1'b0; ad = 2'b10; d = addr; wn = 1'b0;
        end else if (k == 2 + s) begin
            cs = 1'b0; ad = 2'b10; d = addr;
        end else if (k == 3 + s) begin
            cs = 1'b0; d = dd;
        end else if (k <= 3 + 2 * s) begin
            cs = 1'b0; d = dd;
            if (wr) wn = 1'b0;
            else    rn = 1'b0;
        end else if (k == 4 + 2 * s) begin
            cs = 1'b0; d = dd;
        end else if (k == 5 + 2 * s) begin
            rv = 1'b1;
        end else if (k > 4 + 2 * s + r) begin
            rdy = 1'b1;
        end
        return {cs, rn, wn, ad, d, rv, rdy};
    endfunction

    // Runs one transaction on instance 'which' from a negedge, checking
    // every cycle up to the IDLE cycle. With keep set, req_valid stays high
    // so the next call forms a back-to-back request.
    task automatic applyStimulus(input int which, input int s, input int r, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input bit keep, input logic [15:0] exp_rd);
        int waited;
        waited = 0;
        while (getReady(which) !== 1'b1 && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        if (waited >= 50) begin
            checkOutput($sformatf("dut%0d_ready_timeout", which), 32'd0, 32'd1);
            return;
        end
        driveReq(which, 1'b1, wr, addr, wdata);
        for (int k = 1; k <= 5 + 2 * s + r; k++) begin
            @(negedge Clk);
            if (k == 1 && !keep) driveReq(which, 1'b0, 1'b0, 16'h0000, 16'h0000);
            checkOutput($sformatf("dut%0d_cyc%0d", which, k), 32'(getVec(which)),
                        32'(expVec(k, s, r, wr, addr, wdata)));
            if (k == 5 + 2 * s)
                checkOutput($sformatf("dut%0d_rdata", which), 32'(getRdata(which)), 32'(exp_rd));
        end
    endtask

    always @(negedge Clk) begin
        if (mon_on) begin
            checkOutput("excl_a", 32'(strobeViolation(bus_a.hpi_cs_n, bus_a.hpi_r_n, bus_a.hpi_w_n)), 32'd0);
            checkOutput("excl_b", 32'(strobeViolation(bus_b.hpi_cs_n, bus_b.hpi_r_n, bus_b.hpi_w_n)), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        driveReq(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        driveReq(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset state on both instances, then req_ready one edge after release.
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("reset_vec_a", 32'(getVec(0)), 32'(RESET_VEC));
        checkOutput("reset_vec_b", 32'(getVec(1)), 32'(RESET_VEC));
        checkOutput("reset_rdata_a", 32'(getRdata(0)), 32'h0);
        Reset = 1'b0;
        mon_on = 1'b1;
        @(negedge Clk);
        checkOutput("ready_after_reset_a", 32'(getVec(0)), 32'(READY_VEC));
        checkOutput("ready_after_reset_b", 32'(getVec(1)), 32'(READY_VEC));

        // Default-timing write, then read, then a write that must leave
        // the read result alone.
        applyStimulus(0, 4, 2, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 16'h0000);
        rd_value = 16'hA5C3;
        applyStimulus(0, 4, 2, 1'b0, 16'h0500, 16'h7777, 1'b0, 16'hA5C3);
        rd_value = 16'h0F0F;
        applyStimulus(0, 4, 2, 1'b1, 16'h00FF, 16'h5A5A, 1'b0, 16'hA5C3);

        // Back-to-back with req_valid held high across both requests.
        applyStimulus(0, 4, 2, 1'b1, 16'hC001, 16'h1111, 1'b1, 16'hA5C3);
        rd_value = 16'h3C3C;
        applyStimulus(0, 4, 2, 1'b0, 16'hFFFE, 16'h2222, 1'b0, 16'h3C3C);

        // Reset in the middle of a read data strobe.
        rd_value = 16'h9999;
        applyReset();

        // Minimum timing instance: write then read.
        applyStimulus(1, 3, 1, 1'b1, 16'h4321, 16'hCAFE, 1'b0, 16'h0000);
        rd_value = 16'h1357;
        applyStimulus(1, 3, 1, 1'b0, 16'h8000, 16'h0000, 1'b0, 16'h1357);
        applyStimulus(1, 3, 1, 1'b1, 16'h0001, 16'h2468, 1'b1, 16'h1357);
        applyStimulus(1, 3, 1, 1'b1, 16'h0002, 16'h369C, 1'b0, 16'h1357);

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic applyReset();
        int waited;
        waited = 0;
        while (getReady(0) !== 1'b1 && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        if (waited >= 50) begin
            checkOutput("mid_reset_ready_timeout", 32'd0, 32'd1);
            return;
        end
        driveReq(0, 1'b1, 1'b0, 16'h0ABC, 16'h0000);
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            if (k == 1) driveReq(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        checkOutput("mid_dstrobe", 32'(getVec(0)), 32'(expVec(9, 4, 2, 1'b0, 16'h0ABC, 16'h0000)));
        #1 Reset = 1'b1;
        #1;
        checkOutput("mid_reset_now", 32'(getVec(0)), 32'(RESET_VEC));
        checkOutput("mid_reset_rdata", 32'(getRdata(0)), 32'h0);
        @(negedge Clk);
        checkOutput("mid_reset_held", 32'(getVec(0)), 32'(RESET_VEC));
        Reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk);
            checkOutput($sformatf("post_reset_idle%0d", k), 32'(getVec(0)), 32'(READY_VEC));
        end
    endtask

endmodule

// File: doc/hpi_xfer_ctrl.md
HPI_XFER_CTRL -- requirements
Module: hpi_xfer_ctrl

Interface
REQ-001 SHALL have parameter STROBE_CYC, default 4, meaning RD/WR strobe low width in clocks; legal 3..15.
REQ-002 SHALL have parameter RECOV_CYC, default 2, meaning CS-high recovery clocks between transactions; legal 1..15.
REQ-003 SHALL have port Clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  transaction request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = write to CY7C67200 memory, 0 = read.
REQ-008 SHALL have port req_addr  input  16  target CY7C67200 memory address.
REQ-009 SHALL have port req_wdata  input  16  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  16  read result.
REQ-012 SHALL have port hpi_address  output  2  HPI port select to the HPI I/O interface (00 DATA, 10 ADDRESS).
REQ-013 SHALL have port hpi_data_out  output  16  write data to the HPI I/O interface.
REQ-014 SHALL have port hpi_data_in  input  16  registered read data from the HPI I/O interface.
REQ-015 SHALL have ports hpi_r_n, hpi_w_n, hpi_cs_n  output  1 each  active-low read, write, chip-select strobes.

Function
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both 1 (cycle 0), latching req_write, req_addr, req_wdata; inputs are ignored at all other times.
REQ-017 SHALL drive req_ready = 1 only in IDLE; cleared at the accepting edge.
REQ-018 SHALL use FSM states IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, RECOV, sequenced in that order, RECOV -> IDLE.
REQ-019 SHALL be in A_SETUP for 1 cycle: hpi_cs_n=0, hpi_address=10, hpi_data_out=latched addr, strobes high.
REQ-020 SHALL be in A_STROBE for STROBE_CYC cycles with hpi_w_n=0 and all other outputs as in A_SETUP.
REQ-021 SHALL be in A_HOLD for 1 cycle: hpi_w_n=1, cs/address/data unchanged.
REQ-022 SHALL be in D_SETUP for 1 cycle: hpi_cs_n=0, hpi_address=00, hpi_data_out = latched wdata for writes or 0 for reads, strobes high.
REQ-023 SHALL be in D_STROBE for STROBE_CYC cycles, asserting hpi_w_n=0 for writes or hpi_r_n=0 for reads, never both.
REQ-024 SHALL capture hpi_data_in into rsp_rdata on the last D_STROBE cycle of a read; writes leave rsp_rdata unchanged.
REQ-025 SHALL be in D_HOLD for 1 cycle: strobes high, cs_n=0, address/data held.
REQ-026 SHALL be in RECOV for RECOV_CYC cycles: hpi_cs_n=1, strobes high, hpi_address=00, hpi_data_out=0.
REQ-027 SHALL pulse rsp_valid=1 for exactly the first RECOV cycle.
REQ-028 SHALL produce hpi_* outputs as registered values (glitch-free); hpi_r_n and hpi_w_n never both 0, and never 0 while hpi_cs_n=1.
REQ-029 SHALL have total occupancy 5+2*STROBE_CYC+RECOV_CYC cycles: with defaults, accept at cycle 0, rsp_valid at cycle 13, req_ready=1 again at cycle 15.
REQ-030 SHALL keep rsp_rdata stable between captures.
REQ-031 SHALL treat req_valid held high continuously as back-to-back requests, with no overlap and full RECOV between transactions.

Reset
REQ-032 SHALL on Reset=1, immediately and regardless of state: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, hpi_address=00, hpi_data_out=0, hpi_r_n=1, hpi_w_n=1, hpi_cs_n=1.
REQ-033 SHALL raise req_ready on the first rising edge after Reset deasserts; a transaction interrupted by reset is abandoned with no rsp_valid.

Verification
REQ-034 SHALL cover a write with defaults: addr=0x1234, wdata=0xBEEF -> A phase port 10 data 0x1234, w_n low cycles 2-5; D phase port 00 data 0xBEEF, w_n low cycles 8-11; rsp_valid at cycle 13.
REQ-035 SHALL cover a read: addr=0x0500, bench model returns 0xA5C3 with one-cycle registration -> r_n low cycles 8-11, rsp_rdata=0xA5C3 at cycle 13, w_n high during D phase.
REQ-036 SHALL cover back-to-back: req_valid held with two requests -> second accept at cycle 15, cs_n high for cycles 13-14.
REQ-037 SHALL cover reset mid-strobe: Reset asserted in D_STROBE -> all strobes/cs_n high the same cycle, no rsp_valid, req_ready=1 one edge after release.
REQ-038 SHALL cover STROBE_CYC=3, RECOV_CYC=1 -> rsp_valid at cycle 11, req_ready at cycle 12, and strobe-exclusivity assertions (REQ-028) held throughout.
